// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper and the score display.
package score_pkg;

    localparam int unsigned X_POS_W     = 10;
    localparam int unsigned Y_POS_W     = 10;
    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned GLYPH_COLS  = 5;
    localparam int unsigned GLYPH_ROWS  = 7;
    localparam int unsigned GLYPH_SCALE = 2;
    localparam int unsigned SCORE_W     = GLYPH_COLS * GLYPH_SCALE;
    localparam int unsigned SCORE_H     = GLYPH_ROWS * GLYPH_SCALE;
    localparam int unsigned FONT_BITS   = GLYPH_COLS * GLYPH_ROWS;

    // Row-major glyph bitmap: [row][col], row 0 is the top line.
    typedef logic [SCORE_H-1:0][SCORE_W-1:0] glyph_t;

    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        glyph_t             score_val;
    } score_t;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        SCORED    = 2'd1,
        GAME_OVER = 2'd2
    } score_fsm_e;

    // Unscaled 5x7 font; top row in the MSBs, leftmost column is the MSB of each row.
    function automatic logic [FONT_BITS-1:0] font_bits(input logic [DIGIT_W-1:0] digit);
        logic [FONT_BITS-1:0] bits;
        case (digit)
            4'd0:    bits = 35'b01110_10001_10011_10101_11001_10001_01110;
            4'd1:    bits = 35'b00100_01100_00100_00100_00100_00100_01110;
            4'd2:    bits = 35'b01110_10001_00001_00010_00100_01000_11111;
            4'd3:    bits = 35'b11111_00010_00100_00010_00001_10001_01110;
            4'd4:    bits = 35'b00010_00110_01010_10010_11111_00010_00010;
            4'd5:    bits = 35'b11111_10000_11110_00001_00001_10001_01110;
            4'd6:    bits = 35'b00110_01000_10000_11110_10001_10001_01110;
            4'd7:    bits = 35'b11111_00001_00010_00100_01000_01000_01000;
            4'd8:    bits = 35'b01110_10001_10001_01110_10001_10001_01110;
            4'd9:    bits = 35'b01110_10001_10001_01111_00001_00010_01100;
            default: bits = '0;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/score_if.sv
// Score bus between the score keeper (producer) and the score display (consumer).
interface score_if;
    import score_pkg::*;

    score_t player;
    score_t enemy;

    modport keeper_mp  (output player, output enemy);
    modport display_mp (input  player, input  enemy);

endinterface

// File: rtl/digit_glyph_rom.sv
// Combinational digit-to-glyph lookup; the 5x7 font is blown up GLYPH_SCALE times per axis.
module digit_glyph_rom
    import score_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output glyph_t             glyph_c
);

    logic [FONT_BITS-1:0] font_c;

    // Each output pixel samples the font cell it falls inside.
    always_comb begin
        font_c  = font_bits(digit_i);
        glyph_c = '0;
        for (int r = 0; r < int'(SCORE_H); r++) begin
            for (int c = 0; c < int'(SCORE_W); c++) begin
                glyph_c[r][c] = font_c[int'(FONT_BITS) - 1
                                       - int'(GLYPH_COLS) * (r / int'(GLYPH_SCALE))
                                       - (c / int'(GLYPH_SCALE))];
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Owns both match scores, commits them at frame boundaries, sequences serve-hold and game-over.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 9,
    parameter int unsigned HOLD_FRAMES = 60,
    parameter int unsigned PLAYER_X    = 280,
    parameter int unsigned ENEMY_X     = 344,
    parameter int unsigned SCORE_Y     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              player_goal_i,
    input  logic              enemy_goal_i,
    input  logic              frame_end_i,
    input  logic              new_game_i,
    output logic              serve_o,
    output logic              game_over_o,
    output logic              winner_o,
    score_if.keeper_mp        score_o
);

    localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    score_fsm_e          state_q, state_d;
    logic [DIGIT_W-1:0]  player_cnt_q, player_cnt_d;
    logic [DIGIT_W-1:0]  enemy_cnt_q, enemy_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                player_goal_q, player_goal_d;
    logic                enemy_goal_q, enemy_goal_d;
    logic                player_pend_q, player_pend_d;
    logic                enemy_pend_q, enemy_pend_d;
    logic                serve_q, serve_d;
    logic                game_over_q, game_over_d;
    logic                winner_q, winner_d;
    score_t              player_q, player_d;
    score_t              enemy_q, enemy_d;

    logic                player_rise_c, enemy_rise_c;
    logic                glyph_en_c;
    logic [DIGIT_W-1:0]  player_digit_c, enemy_digit_c;
    glyph_t              player_glyph_c, enemy_glyph_c;

    // Look up the glyph of the count being committed; forced to zero while in reset.
    assign player_digit_c = rst_ni ? player_cnt_d : '0;
    assign enemy_digit_c  = rst_ni ? enemy_cnt_d  : '0;

    digit_glyph_rom u_player_rom (
        .digit_i (player_digit_c),
        .glyph_c (player_glyph_c)
    );

    digit_glyph_rom u_enemy_rom (
        .digit_i (enemy_digit_c),
        .glyph_c (enemy_glyph_c)
    );

    // Next-state, score and output logic.
    always_comb begin
        state_d       = state_q;
        player_cnt_d  = player_cnt_q;
        enemy_cnt_d   = enemy_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        player_pend_d = player_pend_q;
        enemy_pend_d  = enemy_pend_q;
        serve_d       = 1'b0;
        winner_d      = winner_q;
        glyph_en_c    = frame_end_i;

        player_goal_d = player_goal_i;
        enemy_goal_d  = enemy_goal_i;
        player_rise_c = player_goal_i & ~player_goal_q;
        enemy_rise_c  = enemy_goal_i & ~enemy_goal_q;

        case (state_q)
            PLAY: begin
                if (player_rise_c) player_pend_d = 1'b1;
                if (enemy_rise_c)  enemy_pend_d  = 1'b1;
                if (frame_end_i && (player_pend_q || enemy_pend_q)) begin
                    // Player wins a same-frame tie; both flags are consumed.
                    player_pend_d = 1'b0;
                    enemy_pend_d  = 1'b0;
                    if (player_pend_q) begin
                        player_cnt_d = player_cnt_q + DIGIT_W'(1);
                        if (player_cnt_d == DIGIT_W'(WIN_SCORE)) begin
                            state_d  = GAME_OVER;
                            winner_d = 1'b0;
                        end else begin
                            state_d    = SCORED;
                            hold_cnt_d = HOLD_W'(HOLD_FRAMES - 1);
                        end
                    end else begin
                        enemy_cnt_d = enemy_cnt_q + DIGIT_W'(1);
                        if (enemy_cnt_d == DIGIT_W'(WIN_SCORE)) begin
                            state_d  = GAME_OVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d    = SCORED;
                            hold_cnt_d = HOLD_W'(HOLD_FRAMES - 1);
                        end
                    end
                end
            end
            SCORED: begin
                player_pend_d = 1'b0;
                enemy_pend_d  = 1'b0;
                if (frame_end_i) begin
                    if (hold_cnt_q == '0) begin
                        serve_d = 1'b1;
                        state_d = PLAY;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
            end
            GAME_OVER: begin
                player_pend_d = 1'b0;
                enemy_pend_d  = 1'b0;
                if (new_game_i) begin
                    player_cnt_d = '0;
                    enemy_cnt_d  = '0;
                    state_d      = SCORED;
                    hold_cnt_d   = HOLD_W'(HOLD_FRAMES - 1);
                    glyph_en_c   = 1'b1;
                end
            end
            default: begin
                state_d = PLAY;
            end
        endcase

        game_over_d = (state_d == GAME_OVER);

        player_d.x_pos     = X_POS_W'(PLAYER_X);
        player_d.y_pos     = Y_POS_W'(SCORE_Y);
        player_d.score_val = glyph_en_c ? player_glyph_c : player_q.score_val;
        enemy_d.x_pos      = X_POS_W'(ENEMY_X);
        enemy_d.y_pos      = Y_POS_W'(SCORE_Y);
        enemy_d.score_val  = glyph_en_c ? enemy_glyph_c : enemy_q.score_val;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= PLAY;
            player_cnt_q  <= '0;
            enemy_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            player_goal_q <= 1'b0;
            enemy_goal_q  <= 1'b0;
            player_pend_q <= 1'b0;
            enemy_pend_q  <= 1'b0;
            serve_q       <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            player_q      <= '{x_pos: X_POS_W'(PLAYER_X), y_pos: Y_POS_W'(SCORE_Y),
                               score_val: player_glyph_c};
            enemy_q       <= '{x_pos: X_POS_W'(ENEMY_X), y_pos: Y_POS_W'(SCORE_Y),
                               score_val: enemy_glyph_c};
        end else begin
            state_q       <= state_d;
            player_cnt_q  <= player_cnt_d;
            enemy_cnt_q   <= enemy_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            player_goal_q <= player_goal_d;
            enemy_goal_q  <= enemy_goal_d;
            player_pend_q <= player_pend_d;
            enemy_pend_q  <= enemy_pend_d;
            serve_q       <= serve_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            player_q      <= player_d;
            enemy_q       <= enemy_d;
        end
    end

    assign serve_o        = serve_q;
    assign game_over_o    = game_over_q;
    assign winner_o       = winner_q;
    assign score_o.player = player_q;
    assign score_o.enemy  = enemy_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE=3, HOLD_FRAMES=3.
module tb_score_keeper;
    import score_pkg::*;

    localparam int unsigned HOLD = 3;
    localparam int unsigned CW   = 160;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic player_goal = 1'b0;
    logic enemy_goal = 1'b0;
    logic frame_end = 1'b0;
    logic new_game = 1'b0;
    logic serve, game_over, winner;
    int   total = 0;
    int   bad = 0;
    int   serve_seen = 0;
    int   serve_mark;

    score_if sif ();

    score_keeper #(
        .WIN_SCORE   (3),
        .HOLD_FRAMES (HOLD),
        .PLAYER_X    (280),
        .ENEMY_X     (344),
        .SCORE_Y     (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .player_goal_i (player_goal),
        .enemy_goal_i  (enemy_goal),
        .frame_end_i   (frame_end),
        .new_game_i    (new_game),
        .serve_o       (serve),
        .game_over_o   (game_over),
        .winner_o      (winner),
        .score_o       (sif)
    );

    always #5 clk = ~clk;

    // Count serve pulses, sampled mid-cycle.
    always @(negedge clk) if (serve) serve_seen++;

    task automatic check_val(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    // Reference glyph built row by row from hand-entered font rows.
    function automatic glyph_t exp_glyph(input int d);
        logic [4:0] rows [7];
        glyph_t g;
        case (d)
            0: rows = '{5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
            1: rows = '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
            2: rows = '{5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
            default: rows = '{5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
        endcase
        g = '0;
        for (int fr = 0; fr < 7; fr++)
            for (int fc = 0; fc < 5; fc++)
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        g[2*fr+dr][2*fc+dc] = rows[fr][4-fc];
        return g;
    endfunction

    task automatic check_scores(input string tag, input int p, input int e);
        check_val({tag, "_player"}, CW'(sif.player.score_val), CW'(exp_glyph(p)));
        check_val({tag, "_enemy"},  CW'(sif.enemy.score_val),  CW'(exp_glyph(e)));
    endtask

    // Run HOLD frames after a commit; serve must appear only after the last one.
    task automatic expect_serve(input string tag);
        for (int i = 0; i < int'(HOLD); i++) begin
            pulse_frame();
            check_val(tag, CW'(serve), CW'(i == int'(HOLD) - 1));
        end
        tick();
        check_val({tag, "_drop"}, CW'(serve), CW'(0));
    endtask

    task automatic goal(input logic p, input logic e);
        player_goal = p;
        enemy_goal  = e;
        tick();
        player_goal = 1'b0;
        enemy_goal  = 1'b0;
        tick();
    endtask

    initial begin
        // 1. Reset with goals asserted
        player_goal = 1'b1;
        enemy_goal  = 1'b1;
        tick(3);
        check_scores("rst", 0, 0);
        check_val("rst_serve", CW'(serve), CW'(0));
        check_val("rst_gover", CW'(game_over), CW'(0));
        check_val("rst_winner", CW'(winner), CW'(0));
        check_val("rst_px", CW'(sif.player.x_pos), CW'(280));
        check_val("rst_ex", CW'(sif.enemy.x_pos), CW'(344));
        check_val("rst_py", CW'(sif.player.y_pos), CW'(16));
        check_val("rst_ey", CW'(sif.enemy.y_pos), CW'(16));
        player_goal = 1'b0;
        enemy_goal  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 2. Commit timing: long goal level, frame end at cycle 1000
        player_goal = 1'b1;
        tick(500);
        player_goal = 1'b0;
        tick(499);
        check_scores("pre_commit", 0, 0);
        frame_end = 1'b1;
        check_scores("commit_edge", 0, 0);
        tick();
        frame_end = 1'b0;
        check_scores("commit", 1, 0);

        // 3. Hold/serve with a goal rise ignored during SCORED
        goal(1'b0, 1'b1);
        expect_serve("serve1");
        check_scores("scored_ignore", 1, 0);
        pulse_frame();
        check_scores("idle_frame", 1, 0);

        // 4. Simultaneous goals: player wins the tie
        goal(1'b1, 1'b1);
        pulse_frame();
        check_scores("tie", 2, 0);
        expect_serve("serve2");

        // 5. Enemy reaches WIN_SCORE
        for (int k = 1; k <= 2; k++) begin
            goal(1'b0, 1'b1);
            pulse_frame();
            check_scores("enemy_pt", 2, k);
            expect_serve("serve_e");
        end
        serve_mark = serve_seen;
        goal(1'b0, 1'b1);
        pulse_frame();
        check_scores("win", 2, 3);
        check_val("win_gover", CW'(game_over), CW'(1));
        check_val("win_winner", CW'(winner), CW'(1));
        goal(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) pulse_frame();
        check_scores("gover_frozen", 2, 3);
        check_val("gover_hold", CW'(game_over), CW'(1));
        check_val("gover_noserve", CW'(serve_seen), CW'(serve_mark));
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check_scores("new_game", 0, 0);
        check_val("ng_gover", CW'(game_over), CW'(0));
        expect_serve("serve_ng");

        // new_game outside GAME_OVER is ignored
        goal(1'b1, 1'b0);
        pulse_frame();
        expect_serve("serve_p");
        serve_mark = serve_seen;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
        check_scores("ng_ignored", 1, 0);
        check_val("ng_ignored_serve", CW'(serve_seen), CW'(serve_mark));

        // 6. Reset in SCORED with hold_cnt=2
        goal(1'b0, 1'b1);
        pulse_frame();
        check_scores("pre_rst", 1, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_scores("mid_rst", 0, 0);
        check_val("mid_rst_gover", CW'(game_over), CW'(0));
        serve_mark = serve_seen;
        for (int i = 0; i < 5; i++) pulse_frame();
        tick();
        check_val("mid_rst_noserve", CW'(serve_seen), CW'(serve_mark));
        check_scores("mid_rst_play", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
